// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell driven one bit per cycle by serial_adder.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one FullAdder and a carry flop, WIDTH+1 cycles per result.
// Handshake: start is accepted on a rising edge where ready=1 and rst_n=1; done pulses one cycle when sum/cout are valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;

    FullAdder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // New sum bit enters at the MSB; written as a shift so WIDTH=1 stays legal.
                sr_d  = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                c_d   = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready     = (state_q != RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sr_q;
    assign cout      = c_q;
    assign state_dbg = state_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds them LSB-first at one bit per clock through a single existing `FullAdder` cell and a carry flip-flop. It returns a WIDTH-bit sum and a carry-out with a one-cycle `done` pulse. It is the sequential stage that drives the combinational `FullAdder` each cycle and consumes its outputs, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Must be at least 1.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request. Sampled only when `ready`=1.
- `a`, input, WIDTH: operand A. Sampled with an accepted `start`.
- `b`, input, WIDTH: operand B. Sampled with an accepted `start`.
- `cin`, input, 1: carry-in. Sampled with an accepted `start`.
- `ready`, output, 1: block can accept `start`. High in IDLE and in DONE.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high for exactly one cycle when the result is valid.
- `sum`, output, WIDTH: result. Held until the next accepted `start`.
- `cout`, output, 1: final carry. Held with `sum`.

## Operation
- Registers:
  - shift registers `sa` and `sb`, WIDTH each
  - result shift register `sr`, WIDTH
  - carry register `c`
  - bit counter `cnt`, $clog2(WIDTH+1) bits
  - FSM state
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - on `start`=1: load `sa`←`a`, `sb`←`b`, `c`←`cin`, `cnt`←0, and go to RUN.
  - `sum` and `cout` keep their last values.
- RUN, each cycle:
  - The `FullAdder` evaluates `sa[0]`, `sb[0]`, `c` → `s`, `co`.
  - Update: `sa`←`sa>>1`, `sb`←`sb>>1`, `sr`←{`s`, `sr[WIDTH-1:1]`}, `c`←`co`, `cnt`←`cnt`+1.
  - When `cnt`==WIDTH-1: go to DONE.
  - `start` is ignored in RUN.
- DONE:
  - `sum`=`sr`, `cout`=`c`, `done`=1 for this cycle only.
  - On `start`=1: reload as in IDLE and go straight to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, exact, modulo 2^(WIDTH+1). There is no overflow flag.
- Reset (`rst_n`=0 at an edge, in any state, including mid-RUN):
  - state←IDLE, `sa`/`sb`/`sr`/`c`/`cnt`←0.
  - The in-flight operation is discarded with no `done` pulse.
- Output values during and after reset: `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0.
- `sum` and `cout` are driven from the registered `sr` and `c`. During RUN they show partial values and are not valid. They are valid only in DONE and in the following IDLE cycles.

## Timing
- `start` accepted at edge E0. RUN occupies edges E1..E(WIDTH).
- `done`=1 in the cycle after edge E(WIDTH), so the first edge sampling `done`=1 is E(WIDTH+1). Latency from accepted `start` to `done` is WIDTH+1 edges.
- Maximum throughput with back-to-back `start`: one result every WIDTH+1 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- `start` asserted at the same edge as `rst_n`=0: reset wins and `start` is dropped.
- WIDTH=1: RUN lasts one cycle (`cnt`==0 terminates immediately).

## Structure
- Package `serial_adder_pkg`:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - localparam function for counter width, $clog2(WIDTH+1)
- Sub-module: one instance of the existing `FullAdder` (a, b, cin → sum, cout), connected to `sa[0]`, `sb[0]`, `c`.
- Everything else stays in the top: FSM, counter, and shift registers.

## Test plan
- Reset check, WIDTH=8: hold `rst_n`=0 for 2 cycles → `ready`=1, `busy`=0, `done`=0, `sum`=0x00, `cout`=0.
- Carry ripple: `a`=0xFF, `b`=0x01, `cin`=0, `start` pulse → `done` 9 edges later with `sum`=0x00, `cout`=1. Repeat with `a`=0x12, `b`=0x34, `cin`=0 → `sum`=0x46, `cout`=0.
- Carry-in path: `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1. With `cin`=0 → `sum`=0xFF, `cout`=0.
- Start in RUN is ignored: pulse `start` with different operands 3 cycles into RUN → the first result is unchanged, a single `done` pulse occurs, and `ready` stays 0 until DONE.
- Back-to-back: assert `start` in the DONE cycle with 0x80+0x80, `cin`=0 → no IDLE cycle, second `done` 9 edges later with `sum`=0x00, `cout`=1.
- Reset mid-op: drop `rst_n` for one edge at RUN bit 4 → no `done` pulse, outputs return to their reset values, and a fresh `start` afterwards produces a correct result. Also run an exhaustive random compare against `a`+`b`+`cin` for WIDTH=1 and WIDTH=8.
